// File: rtl/systolic_pkg.sv
// systolic_pkg: feeder state encoding, default array geometry and the lane slicing helper
// shared by the systolic array operand feeder.
package systolic_pkg;

  localparam int DEFAULT_DATA_W     = 16;
  localparam int DEFAULT_ARRAY_SIZE = 2;
  localparam int DEFAULT_K_MAX      = 255;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    FLUSH,
    WAIT_DONE,
    DONE
  } feeder_state_t;

  // Lane i of a flattened operand bus occupies [i*dataW +: dataW].
  function automatic int lane_lsb(input int lane, input int dataW);
    return lane * dataW;
  endfunction

endpackage

// File: rtl/feeder_skew_line.sv
// feeder_skew_line: per-lane operand delay line of DEPTH registers that advance only while
// en_i is high; DEPTH=0 degenerates to a plain wire.
module feeder_skew_line #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  if (DEPTH == 0) begin : gWire
    logic unusedCtl;
    assign unusedCtl = clk ^ rst ^ en_i;
    assign q_o       = d_i;
  end else begin : gRegs
    logic [DATA_W-1:0] stages_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < DEPTH; s++) stages_q[s] <= '0;
      end else if (en_i) begin
        stages_q[0] <= d_i;
        for (int s = 1; s < DEPTH; s++) stages_q[s] <= stages_q[s-1];
      end
    end

    assign q_o = stages_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: accepts K operand beats, skews lane i by i cycles onto the array, flushes,
// waits for compute_done and pulses done. FEEDER_STALL_CNT_EN adds the stall_cnt bubble counter.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter  int DATA_W     = DEFAULT_DATA_W,
  parameter  int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
  parameter  int K_MAX      = DEFAULT_K_MAX,
  localparam int K_W        = $clog2(K_MAX + 1),
  localparam int BUS_W      = ARRAY_SIZE * DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [K_W-1:0]   k_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [BUS_W-1:0] a_data,
  input  logic [BUS_W-1:0] b_data,
  output logic [BUS_W-1:0] arr_data,
  output logic [BUS_W-1:0] arr_weight,
  output logic             systolic_en,
  output logic             read_all_data,
  input  logic             compute_done,
  output logic             busy,
  output logic             done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int FL_W = $clog2(ARRAY_SIZE + 1);

  feeder_state_t    state_q, state_d;
  logic [K_W-1:0]   kLen_q, beatCnt_q;
  logic [FL_W-1:0]  flushCnt_q;
  logic [BUS_W-1:0] aIn, bIn, aSkew, bSkew, arrData_q, arrWeight_q;
  logic             startAccept, accept, shiftEn, lastBeat, flushLast;

  assign startAccept = (state_q == IDLE) && start;
  assign accept      = (state_q == FEED) && op_valid;
  assign shiftEn     = (state_q == FEED) || (state_q == FLUSH);
  assign lastBeat    = (beatCnt_q + K_W'(1)) == kLen_q;
  assign flushLast   = int'(flushCnt_q) == (ARRAY_SIZE - 2);

  // A FEED cycle without a beat still shifts the lanes, carrying a zero bubble.
  assign aIn = accept ? a_data : '0;
  assign bIn = accept ? b_data : '0;

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : gLane
    feeder_skew_line #(.DATA_W(DATA_W), .DEPTH(i)) uSkewA (
      .clk (clk),
      .rst (rst),
      .en_i(shiftEn),
      .d_i (aIn[lane_lsb(i, DATA_W) +: DATA_W]),
      .q_o (aSkew[lane_lsb(i, DATA_W) +: DATA_W])
    );
    feeder_skew_line #(.DATA_W(DATA_W), .DEPTH(i)) uSkewB (
      .clk (clk),
      .rst (rst),
      .en_i(shiftEn),
      .d_i (bIn[lane_lsb(i, DATA_W) +: DATA_W]),
      .q_o (bSkew[lane_lsb(i, DATA_W) +: DATA_W])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      kLen_q      <= '0;
      beatCnt_q   <= '0;
      flushCnt_q  <= '0;
      arrData_q   <= '0;
      arrWeight_q <= '0;
    end else begin
      state_q <= state_d;
      if (startAccept) begin
        kLen_q    <= k_len;
        beatCnt_q <= '0;
      end else if (accept) begin
        beatCnt_q <= beatCnt_q + K_W'(1);
      end
      flushCnt_q  <= (state_q == FLUSH) ? flushCnt_q + FL_W'(1) : '0;
      arrData_q   <= shiftEn ? aSkew : '0;
      arrWeight_q <= shiftEn ? bSkew : '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_ready      = 1'b0;
    systolic_en   = 1'b0;
    read_all_data = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (k_len == '0) ? DONE : FEED;
      end
      FEED: begin
        op_ready    = 1'b1;
        systolic_en = 1'b1;
        if (accept && lastBeat) state_d = (ARRAY_SIZE > 1) ? FLUSH : WAIT_DONE;
      end
      FLUSH: begin
        systolic_en = 1'b1;
        if (flushLast) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        systolic_en   = 1'b1;
        read_all_data = 1'b1;
        if (compute_done) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign arr_data   = arrData_q;
  assign arr_weight = arrWeight_q;

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stallCnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt_q <= '0;
    end else if (startAccept) begin
      stallCnt_q <= '0;
    end else if ((state_q == FEED) && !op_valid && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_q <= stallCnt_q + 16'd1;
    end
  end

  assign stall_cnt = stallCnt_q;
`else
  // Without the counter a missing beat is only a zero slot on every lane.
`endif

endmodule
